// File: rtl/metronome_beat_scheduler.sv
// metronome_beat_scheduler
//   Beat scheduler for the metronome. Holds the active tempo and run state and
//   emits one-cycle beat pulses from an exact phase accumulator: each cycle in
//   RUN the tempo (BPM) is added to a 34-bit accumulator. A beat fires when the
//   accumulator reaches THRESH = CLK_HZ*60. This gives an average interval of
//   exactly THRESH/bpm cycles without a divider.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start, i_stop       level-sampled run control (stop wins)
//   i_bpm, i_bpm_load     tempo value and its one-cycle load strobe
//   i_beats_per_bar       bar length (0 behaves as 1)
//   o_trigger, o_accent   beat pulse and first-beat-of-bar pulse
//   o_beat_idx            index of the most recently emitted beat
//   o_bpm_counter         active tempo, zero-extended to 34 bits
//   o_running             high while in RUN
//   o_bpm_clamped         sticky: last tempo load was out of range
module metronome_beat_scheduler #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BPM_MIN     = 1,
    parameter int BPM_MAX     = 9999,
    parameter int BPM_DEFAULT = 1200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [13:0] i_bpm,
    input  logic        i_bpm_load,
    input  logic [3:0]  i_beats_per_bar,
    output logic        o_trigger,
    output logic        o_accent,
    output logic [3:0]  o_beat_idx,
    output logic [33:0] o_bpm_counter,
    output logic        o_running,
    output logic        o_bpm_clamped
);

    // CLK_HZ*60 overflows 32 bits at realistic clock rates, so form it in 64.
    localparam longint      THRESH_L  = longint'(CLK_HZ) * 64'd60;
    localparam logic [33:0] THRESH    = THRESH_L[33:0];
    localparam logic [13:0] BPM_MIN_C = 14'(BPM_MIN);
    localparam logic [13:0] BPM_MAX_C = 14'(BPM_MAX);
    localparam logic [13:0] BPM_DEF_C = 14'(BPM_DEFAULT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [33:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  bpb_q, bpb_d;
    logic [13:0] bpm_q, bpm_d;
    logic        clamped_q, clamped_d;
    logic        trig_q, trig_d;
    logic        accent_q, accent_d;
    logic [3:0]  beat_idx_q, beat_idx_d;

    logic [3:0]  bpb_in;
    logic [3:0]  bpb_lim;
    logic [33:0] bpm_ext;
    logic [33:0] sum;
    logic        hit;
    logic [4:0]  idx_nxt;
    logic        idx_wrap;

    assign bpb_in  = (i_beats_per_bar == 4'd0) ? 4'd1 : i_beats_per_bar;
    // The latched bar length only grows at a bar boundary, but a shorter live
    // setting takes effect immediately so a shrink mid-bar wraps on the next beat.
    assign bpb_lim = (bpb_in < bpb_q) ? bpb_in : bpb_q;
    assign bpm_ext = {20'b0, bpm_q};
    // acc < THRESH and bpm <= BPM_MAX keep this below 2^34, and at most one
    // wrap can happen per cycle.
    assign sum      = acc_q + bpm_ext;
    assign hit      = (sum >= THRESH);
    assign idx_nxt  = {1'b0, idx_q} + 5'd1;
    assign idx_wrap = (idx_nxt >= {1'b0, bpb_lim});

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        bpb_d      = bpb_q;
        bpm_d      = bpm_q;
        clamped_d  = clamped_q;
        trig_d     = 1'b0;
        accent_d   = 1'b0;
        beat_idx_d = beat_idx_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = S_RUN;
                    // Preloading THRESH-bpm makes the first add land exactly on
                    // THRESH, so the first beat comes one cycle after start.
                    acc_d   = THRESH - bpm_ext;
                    idx_d   = 4'd0;
                    bpb_d   = bpb_in;
                end
            end
            default: begin
                if (i_stop) begin
                    // Phase and index are frozen; a restart re-initialises them.
                    state_d = S_IDLE;
                end else if (hit) begin
                    acc_d      = sum - THRESH;
                    trig_d     = 1'b1;
                    accent_d   = (idx_q == 4'd0);
                    beat_idx_d = idx_q;
                    if (idx_wrap) begin
                        idx_d = 4'd0;
                        bpb_d = bpb_in;
                    end else begin
                        idx_d = idx_nxt[3:0];
                    end
                end else begin
                    acc_d = sum;
                end
            end
        endcase

        // Tempo load leaves the accumulator alone so the beat phase carries over.
        if (i_bpm_load) begin
            if (i_bpm < BPM_MIN_C) begin
                bpm_d = BPM_MIN_C;
            end else if (i_bpm > BPM_MAX_C) begin
                bpm_d = BPM_MAX_C;
            end else begin
                bpm_d = i_bpm;
            end
            clamped_d = (i_bpm < BPM_MIN_C) || (i_bpm > BPM_MAX_C);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            idx_q      <= 4'd0;
            bpb_q      <= 4'd1;
            bpm_q      <= BPM_DEF_C;
            clamped_q  <= 1'b0;
            trig_q     <= 1'b0;
            accent_q   <= 1'b0;
            beat_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            bpb_q      <= bpb_d;
            bpm_q      <= bpm_d;
            clamped_q  <= clamped_d;
            trig_q     <= trig_d;
            accent_q   <= accent_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    assign o_trigger     = trig_q;
    assign o_accent      = accent_q;
    assign o_beat_idx    = beat_idx_q;
    assign o_bpm_counter = {20'b0, bpm_q};
    assign o_running     = (state_q == S_RUN);
    assign o_bpm_clamped = clamped_q;

endmodule
